// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, opcode map, FSM states and the operand-need decode
// used by both decode and execute/writeback.
package pipeline_pkg;

   localparam int unsigned REG_W   = 4;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned SHAMT_W = $clog2(DATA_W);

   localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OP_W-1:0] OP_ADD   = 4'h1;
   localparam logic [OP_W-1:0] OP_SUB   = 4'h2;
   localparam logic [OP_W-1:0] OP_MUL   = 4'h3;
   localparam logic [OP_W-1:0] OP_AND   = 4'h4;
   localparam logic [OP_W-1:0] OP_OR    = 4'h5;
   localparam logic [OP_W-1:0] OP_XOR   = 4'h6;
   localparam logic [OP_W-1:0] OP_NOT   = 4'h7;
   localparam logic [OP_W-1:0] OP_SHL   = 4'h8;
   localparam logic [OP_W-1:0] OP_SHR   = 4'h9;
   localparam logic [OP_W-1:0] OP_LOAD  = 4'hE;
   localparam logic [OP_W-1:0] OP_STORE = 4'hF;

   typedef enum logic {ST_IDLE, ST_MUL_BUSY} ewu_state_e;

   typedef struct packed {
      logic src1;
      logic src2;
   } needs_t;

   // Which operands an opcode actually reads; stale flags on unread operands never stall.
   function automatic needs_t needs_operands(input logic [OP_W-1:0] op);
      needs_t n;
      n = '0;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            n.src1 = 1'b1;
            n.src2 = 1'b1;
         end
         OP_NOT, OP_STORE: n.src1 = 1'b1;
         default: n = '0;
      endcase
      return n;
   endfunction

   // NOP and the reserved block 1010-1101 never issue.
   function automatic logic is_active(input logic [OP_W-1:0] op);
      logic act;
      case (op)
         OP_NOP, 4'hA, 4'hB, 4'hC, 4'hD: act = 1'b0;
         default:                        act = 1'b1;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial product per step, low DATA_W bits kept.
module shift_add_multiplier
   import pipeline_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] product_c,
   output logic              done_c
);

   localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] multiplicand;
   logic [DATA_W-1:0] multiplier;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] partial;

   assign partial   = multiplier[0] ? multiplicand : '0;
   assign product_c = acc + partial;
   assign done_c    = step && (count == CNT_W'(MUL_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count        <= '0;
         multiplicand <= '0;
         multiplier   <= '0;
         acc          <= '0;
      end else if (start) begin
         count        <= '0;
         multiplicand <= a;
         multiplier   <= b;
         acc          <= '0;
      end else if (step) begin
         count        <= count + CNT_W'(1);
         multiplicand <= multiplicand << 1;
         multiplier   <= multiplier >> 1;
         acc          <= product_c;
      end
   end

endmodule

// File: rtl/execute_writeback_unit.sv
// Execute/writeback stage: ALU, iterative multiply and LOAD/STORE to a local data memory,
// returning one register write per completed instruction and a stall to decode/fetch.
module execute_writeback_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned DMEM_DEPTH = 256,
   parameter int unsigned MUL_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   opcode,
   input  logic [REG_W-1:0]  destReg,
   input  logic [DATA_W-1:0] srcVal1,
   input  logic [DATA_W-1:0] srcVal2,
   input  logic [ADDR_W-1:0] memAddr,
   input  logic              used1,
   input  logic              used2,
   output logic              stall,
   output logic              regWrEn,
   output logic [REG_W-1:0]  regWrAddr,
   output logic [DATA_W-1:0] regWrData,
   output logic              zeroFlag
);

   ewu_state_e        state;
   needs_t            needs;
   logic              hazard;
   logic              issue;
   logic              mul_start;
   logic              mul_step;
   logic              mul_done_c;
   logic [DATA_W-1:0] mul_product_c;
   logic [REG_W-1:0]  mul_dest;
   logic [DATA_W-1:0] result;

   // Power-up contents are zero; reset deliberately leaves memory untouched.
   logic [DATA_W-1:0] dmem [DMEM_DEPTH] = '{default: '0};

   assign needs     = needs_operands(opcode);
   assign hazard    = (needs.src1 & used1) | (needs.src2 & used2);
   assign stall     = hazard | (state == ST_MUL_BUSY);
   assign issue     = !stall && is_active(opcode);
   assign mul_start = issue && (opcode == OP_MUL);
   assign mul_step  = (state == ST_MUL_BUSY);

   shift_add_multiplier #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start     (mul_start),
      .step      (mul_step),
      .a         (srcVal1),
      .b         (srcVal2),
      .product_c (mul_product_c),
      .done_c    (mul_done_c)
   );

   // Single-cycle result; shift amounts of DATA_W or more flush to zero.
   always_comb begin
      result = '0;
      case (opcode)
         OP_ADD:  result = srcVal1 + srcVal2;
         OP_SUB:  result = srcVal1 - srcVal2;
         OP_AND:  result = srcVal1 & srcVal2;
         OP_OR:   result = srcVal1 | srcVal2;
         OP_XOR:  result = srcVal1 ^ srcVal2;
         OP_NOT:  result = ~srcVal1;
         OP_SHL:  result = (srcVal2 >= DATA_W'(DATA_W)) ? '0 : (srcVal1 << srcVal2[SHAMT_W-1:0]);
         OP_SHR:  result = (srcVal2 >= DATA_W'(DATA_W)) ? '0 : (srcVal1 >> srcVal2[SHAMT_W-1:0]);
         OP_LOAD: result = dmem[memAddr];
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && issue && (opcode == OP_STORE)) begin
         dmem[memAddr] <= srcVal1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         mul_dest  <= '0;
         regWrEn   <= 1'b0;
         regWrAddr <= '0;
         regWrData <= '0;
         zeroFlag  <= 1'b0;
      end else begin
         regWrEn <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mul_start) begin
                  state    <= ST_MUL_BUSY;
                  mul_dest <= destReg;
               end else if (issue && (opcode != OP_STORE)) begin
                  regWrEn   <= 1'b1;
                  regWrAddr <= destReg;
                  regWrData <= result;
                  zeroFlag  <= (result == '0);
               end
            end
            ST_MUL_BUSY: begin
               if (mul_done_c) begin
                  state     <= ST_IDLE;
                  regWrEn   <= 1'b1;
                  regWrAddr <= mul_dest;
                  regWrData <= mul_product_c;
                  zeroFlag  <= (mul_product_c == '0);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_writeback_unit.sv
// Bench for execute_writeback_unit: vector table plus multi-cycle sequences, with a
// scoreboard of expected register writes tagged by the cycle they must appear in.
module tb_execute_writeback_unit;
   import pipeline_pkg::*;

   logic              clk;
   logic              rst;
   logic [OP_W-1:0]   opcode;
   logic [REG_W-1:0]  destReg;
   logic [DATA_W-1:0] srcVal1;
   logic [DATA_W-1:0] srcVal2;
   logic [ADDR_W-1:0] memAddr;
   logic              used1;
   logic              used2;
   logic              stall;
   logic              regWrEn;
   logic [REG_W-1:0]  regWrAddr;
   logic [DATA_W-1:0] regWrData;
   logic              zeroFlag;

   execute_writeback_unit dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .destReg   (destReg),
      .srcVal1   (srcVal1),
      .srcVal2   (srcVal2),
      .memAddr   (memAddr),
      .used1     (used1),
      .used2     (used2),
      .stall     (stall),
      .regWrEn   (regWrEn),
      .regWrAddr (regWrAddr),
      .regWrData (regWrData),
      .zeroFlag  (zeroFlag)
   );

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  dest;
      logic [15:0] s1;
      logic [15:0] s2;
      logic [7:0]  addr;
      logic        u1;
      logic        u2;
      logic        we;
      logic [15:0] data;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [3:0]  addr;
      logic [15:0] data;
      logic        zero;
   } wr_t;

   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   logic model_zero = 1'b0;
   wr_t  sb[$];
   vec_t vecs[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] dest, input logic [15:0] s1,
                        input logic [15:0] s2, input logic [7:0] addr, input logic u1, input logic u2);
      opcode  = op;
      destReg = dest;
      srcVal1 = s1;
      srcVal2 = s2;
      memAddr = addr;
      used1   = u1;
      used2   = u2;
   endtask

   task automatic expect_write(input int at_cyc, input logic [3:0] addr, input logic [15:0] data);
      wr_t w;
      w.cyc  = at_cyc;
      w.addr = addr;
      w.data = data;
      w.zero = (data == 16'h0);
      model_zero = w.zero;
      sb.push_back(w);
   endtask

   // Scoreboard side: every write must match the oldest expectation, in its exact cycle.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         compared++;
         mismatched++;
         $display("FAIL wr_missed: no write to r%0d (data 0x%0h) in cycle %0d, now cycle %0d",
                  sb[0].addr, sb[0].data, sb[0].cyc, cyc);
         void'(sb.pop_front());
      end
      if (regWrEn === 1'b1) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL wr_unexpected: r%0d <= 0x%0h in cycle %0d, none expected",
                     regWrAddr, regWrData, cyc);
         end else begin
            wr_t w;
            w = sb.pop_front();
            check("wr_cycle", cyc, w.cyc);
            check("wr_addr", regWrAddr, w.addr);
            check("wr_data", regWrData, w.data);
            check("wr_zero", zeroFlag, w.zero);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      drive(OP_ADD, 4'd1, 16'd1, 16'd1, 8'd0, 1'b0, 1'b0);

      // op, dest, s1, s2, addr, u1, u2, we, data
      vecs.push_back('{OP_ADD,   4'd3,  16'd40,   16'd50,   8'h00, 1'b0, 1'b0, 1'b1, 16'd90});
      vecs.push_back('{OP_SUB,   4'd4,  16'd5,    16'd5,    8'h00, 1'b0, 1'b0, 1'b1, 16'd0});
      vecs.push_back('{OP_AND,   4'd5,  16'hF0F0, 16'hFF00, 8'h00, 1'b0, 1'b0, 1'b1, 16'hF000});
      vecs.push_back('{OP_OR,    4'd6,  16'hF0F0, 16'h0F00, 8'h00, 1'b0, 1'b0, 1'b1, 16'hFFF0});
      vecs.push_back('{OP_XOR,   4'd1,  16'hFFFF, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b1, 16'hFF00});
      vecs.push_back('{OP_NOT,   4'd2,  16'h00FF, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 16'hFF00});
      vecs.push_back('{OP_SHL,   4'd8,  16'h0001, 16'd20,   8'h00, 1'b0, 1'b0, 1'b1, 16'h0000});
      vecs.push_back('{OP_SHR,   4'd9,  16'h8000, 16'd15,   8'h00, 1'b0, 1'b0, 1'b1, 16'h0001});
      vecs.push_back('{OP_ADD,   4'd10, 16'hFFFF, 16'd2,    8'h00, 1'b0, 1'b0, 1'b1, 16'h0001});
      vecs.push_back('{OP_SUB,   4'd11, 16'h0000, 16'd1,    8'h00, 1'b0, 1'b0, 1'b1, 16'hFFFF});
      vecs.push_back('{OP_NOP,   4'd12, 16'd7,    16'd7,    8'h00, 1'b0, 1'b0, 1'b0, 16'h0000});
      vecs.push_back('{4'hC,     4'd13, 16'd7,    16'd7,    8'h00, 1'b0, 1'b0, 1'b0, 16'h0000});
      vecs.push_back('{OP_STORE, 4'd5,  16'hBEEF, 16'd0,    8'h2A, 1'b0, 1'b0, 1'b0, 16'h0000});
      vecs.push_back('{OP_LOAD,  4'd7,  16'd0,    16'd0,    8'h2A, 1'b0, 1'b0, 1'b1, 16'hBEEF});
      vecs.push_back('{OP_LOAD,  4'd14, 16'd0,    16'd0,    8'h10, 1'b0, 1'b0, 1'b1, 16'h0000});
      vecs.push_back('{OP_NOT,   4'd2,  16'h1234, 16'd0,    8'h00, 1'b0, 1'b1, 1'b1, 16'hEDCB});
      vecs.push_back('{OP_SHL,   4'd15, 16'h0003, 16'd4,    8'h00, 1'b0, 1'b0, 1'b1, 16'h0030});
      vecs.push_back('{OP_LOAD,  4'd6,  16'd0,    16'd0,    8'h00, 1'b1, 1'b1, 1'b1, 16'h0000});
      vecs.push_back('{OP_SUB,   4'd4,  16'd9,    16'd9,    8'h00, 1'b0, 1'b0, 1'b1, 16'h0000});

      // Reset with a live ADD presented: nothing may issue.
      repeat (2) @(posedge clk);
      #1;
      check("rst_wren", regWrEn, 0);
      check("rst_data", regWrData, 0);
      check("rst_zero", zeroFlag, 0);
      check("rst_stall", stall, 0);
      drive(OP_NOP, 4'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Back-to-back vector table.
      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         drive(vecs[i].op, vecs[i].dest, vecs[i].s1, vecs[i].s2, vecs[i].addr, vecs[i].u1, vecs[i].u2);
         #3;
         check("vec_stall", stall, 0);
         if (vecs[i].we) expect_write(cyc + 1, vecs[i].dest, vecs[i].data);
      end
      @(posedge clk);
      #1;
      drive(OP_NOP, 4'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("zero_hold", zeroFlag, model_zero);

      // Stale operand 2 holds the ADD until the refreshed value arrives.
      drive(OP_ADD, 4'd3, 16'd7, 16'd999, 8'd0, 1'b0, 1'b1);
      #3;
      check("hazard_stall", stall, 1);
      repeat (2) begin
         @(posedge clk);
         #4;
         check("hazard_hold", stall, 1);
      end
      @(posedge clk);
      #1;
      drive(OP_ADD, 4'd3, 16'd7, 16'd80, 8'd0, 1'b0, 1'b0);
      #3;
      check("hazard_clear", stall, 0);
      expect_write(cyc + 1, 4'd3, 16'd87);
      @(posedge clk);
      #1;
      drive(OP_NOP, 4'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);

      // MUL 300*300 with an ADD waiting behind it.
      @(posedge clk);
      #1;
      drive(OP_MUL, 4'd12, 16'd300, 16'd300, 8'd0, 1'b0, 1'b0);
      expect_write(cyc + 1 + 16, 4'd12, 16'h5F90);
      expect_write(cyc + 1 + 17, 4'd13, 16'd3);
      @(posedge clk);
      #1;
      drive(OP_ADD, 4'd13, 16'd1, 16'd2, 8'd0, 1'b0, 1'b0);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (stall === 1'b1) n++;
         else break;
      end
      check("mul_stall_cycles", n, 16);
      @(posedge clk);
      #1;
      drive(OP_NOP, 4'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);

      // Reset in the 8th busy cycle aborts the multiply silently.
      repeat (2) @(posedge clk);
      #1;
      drive(OP_MUL, 4'd9, 16'd300, 16'd300, 8'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(OP_NOP, 4'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      check("mul_busy_pre_rst", stall, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_stall", stall, 0);
      check("abort_wren", regWrEn, 0);
      check("abort_addr", regWrAddr, 0);
      check("abort_data", regWrData, 0);
      check("abort_zero", zeroFlag, 0);
      repeat (30) @(posedge clk);

      for (int k = 0; k < 50; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
